// File: rtl/iobuf_bank_pkg.sv
// iobuf_bank_pkg: shared types, parameter limits and helpers for the pad buffer bank.
// Optional feature macro: IOBUF_BANK_OPEN_DRAIN_EN (consumed by iobuf_chan).
`timescale 1ns/100ps

package iobuf_bank_pkg;

  // Per-channel direction state machine encoding.
  typedef enum logic [1:0] {
    RX      = 2'd0,
    TURN_TX = 2'd1,
    TX      = 2'd2,
    TURN_RX = 2'd3
  } chan_state_e;

  // Legal parameter ranges.
  localparam int CH_MIN          = 1;
  localparam int CH_MAX          = 32;
  localparam int TURN_CYC_MIN    = 0;
  localparam int TURN_CYC_MAX    = 15;
  localparam int SYNC_STAGES_MIN = 1;
  localparam int SYNC_STAGES_MAX = 4;

  // Turnaround counter width; never narrower than one bit so TURN_CYC=0 still elaborates.
  function automatic int cnt_width(input int turn_cyc);
    int w;
    w = $clog2(turn_cyc + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/iobuf_chan.sv
// iobuf_chan: one bidirectional pad channel -- direction FSM with turnaround
// counter, registered drive data, receive synchroniser and pad driver.
// Optional feature macro: IOBUF_BANK_OPEN_DRAIN_EN selects open-drain drive in TX.
//
// Direction handshake: z is a level request sampled on every rising edge
// (1 = release the pad, 0 = drive it). oe rises only after the full turnaround
// has elapsed; busy is high exactly while the channel sits in a turnaround state.
`timescale 1ns/100ps

import iobuf_bank_pkg::*;

module iobuf_chan #(
  parameter int TURN_CYC    = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        z,
  input  logic        din,
  output logic        dout,
  output logic        oe,
  output logic        busy,
  output chan_state_e state,
  inout  wire         pad
);

  localparam int              CW       = cnt_width(TURN_CYC);
  localparam logic [CW-1:0]   CNT_LOAD = CW'(TURN_CYC);
  localparam logic [CW-1:0]   CNT_ONE  = CW'(1);

  chan_state_e                state_q;
  chan_state_e                state_d;
  logic [CW-1:0]              cnt_q;
  logic [CW-1:0]              cnt_d;
  logic                       oe_q;
  logic                       busy_q;
  logic                       drv_q;
  logic [SYNC_STAGES-1:0]     sync_q;

  // Next-state and counter logic; turnaround into RX always runs to completion.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      RX: begin
        if (!z) begin
          if (TURN_CYC == 0) begin
            state_d = TX;
          end else begin
            state_d = TURN_TX;
            cnt_d   = CNT_LOAD;
          end
        end
      end
      TURN_TX: begin
        if (z) begin
          state_d = RX;
        end else if (cnt_q == CNT_ONE) begin
          state_d = TX;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      TX: begin
        if (z) begin
          if (TURN_CYC == 0) begin
            state_d = RX;
          end else begin
            state_d = TURN_RX;
            cnt_d   = CNT_LOAD;
          end
        end
      end
      TURN_RX: begin
        if (cnt_q == CNT_ONE) begin
          state_d = RX;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d = RX;
        cnt_d   = '0;
      end
    endcase
  end

  // State, counter, drive data and registered decodes of the next state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= RX;
      cnt_q   <= '0;
      oe_q    <= 1'b0;
      busy_q  <= 1'b0;
      drv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      oe_q    <= (state_d == TX);
      busy_q  <= (state_d == TURN_TX) || (state_d == TURN_RX);
      drv_q   <= din;
    end
  end

  // Receive synchroniser; the pad is sampled in every state so TX loops back.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q[0] <= pad;
      for (int j = 1; j < SYNC_STAGES; j++) begin
        sync_q[j] <= sync_q[j-1];
      end
    end
  end

`ifdef IOBUF_BANK_OPEN_DRAIN_EN
  // Open-drain: only ever pull low; a 1 is produced by the board pull-up.
  assign pad = (oe_q && !drv_q) ? 1'b0 : 1'bz;
`else
  // Push-pull: drive both levels while in TX.
  assign pad = oe_q ? drv_q : 1'bz;
`endif

  assign dout  = sync_q[SYNC_STAGES-1];
  assign oe    = oe_q;
  assign busy  = busy_q;
  assign state = state_q;

endmodule

// File: rtl/iobuf_bank.sv
// iobuf_bank: CH independent bidirectional pad channels with programmable
// turnaround dead cycles and a synchronised receive path.
// Optional feature macro: IOBUF_BANK_OPEN_DRAIN_EN (open-drain drive in TX).
`timescale 1ns/100ps

import iobuf_bank_pkg::*;

module iobuf_bank #(
  parameter int CH          = 3,
  parameter int TURN_CYC    = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [CH-1:0] z,
  input  logic [CH-1:0] din,
  output logic [CH-1:0] dout,
  inout  wire  [CH-1:0] dinout,
  output logic [CH-1:0] oe,
  output logic [CH-1:0] busy
);

  chan_state_e chan_state [CH];

  for (genvar i = 0; i < CH; i++) begin : g_chan
    iobuf_chan #(
      .TURN_CYC    (TURN_CYC),
      .SYNC_STAGES (SYNC_STAGES)
    ) u_chan (
      .clk   (clk),
      .rst_n (rst_n),
      .z     (z[i]),
      .din   (din[i]),
      .dout  (dout[i]),
      .oe    (oe[i]),
      .busy  (busy[i]),
      .state (chan_state[i]),
      .pad   (dinout[i])
    );

    // oe and busy must be consistent with the channel state and never overlap.
    always_ff @(posedge clk) begin
      if (rst_n) begin
        assert (oe[i] == (chan_state[i] == TX));
        assert (busy[i] == ((chan_state[i] == TURN_TX) || (chan_state[i] == TURN_RX)));
        assert (!(oe[i] && busy[i]));
      end
    end
  end

  // Parameter range guards.
  always_ff @(posedge clk) begin
    assert (CH >= CH_MIN && CH <= CH_MAX);
    assert (TURN_CYC >= TURN_CYC_MIN && TURN_CYC <= TURN_CYC_MAX);
    assert (SYNC_STAGES >= SYNC_STAGES_MIN && SYNC_STAGES <= SYNC_STAGES_MAX);
  end

endmodule

// File: doc/iobuf_bank.md
# iobuf_bank

Parametrised bank of bidirectional pad buffers: CH independent channels, each with registered drive data, a synchronised receive path and a per-channel direction state machine. The state machine inserts programmable turnaround dead cycles so that a channel never drives the pad in the same cycle it stops receiving, or the reverse. The block sits between core logic and the top-level inout pads and replaces hand-instantiated per-pin tristate buffers.

## Interface
- CH, 3: number of channels, 1..32.
- TURN_CYC, 1: dead cycles on each direction change, 0..15.
- SYNC_STAGES, 2: receive synchroniser depth, 1..4.

- clk  input  1  bank clock; all state updates on its rising edge.
- rst_n  input  1  reset, synchronous and active-low.
- z  input  CH  per-channel direction request: 1 = receive (pad released), 0 = drive.
- din  input  CH  data to drive onto the pad.
- dout  output  CH  synchronised pad value.
- dinout  inout  CH  pad.
- oe  output  CH  1 while the channel is driving its pad.
- busy  output  CH  1 while the channel is in a turnaround state.

## Operation
- Per-channel FSM with states RX, TURN_TX, TX, TURN_RX. Counter width is $clog2(TURN_CYC+1), minimum 1.
- RX: pad released. z=0 → TURN_TX with cnt=TURN_CYC, or directly → TX when TURN_CYC=0.
- TURN_TX: pad released, busy=1.
  - z=1 → RX (abort; the channel never drives).
  - Otherwise, cnt==1 → TX; else cnt decrements.
- TX: pad driven from drv_q. z=1 → TURN_RX with cnt=TURN_CYC, or → RX when TURN_CYC=0.
- TURN_RX: pad released, busy=1.
  - Always completes: cnt==1 → RX; else cnt decrements.
  - z is ignored here and re-evaluated in RX.
- drv_q <= din[i] every cycle.
- Pad drive: dinout[i] = oe[i] ? drv_q : 1'bz (push-pull build).
- oe and busy are registered decodes of the next state, so they change on the same edge as the state.
- dout[i] is dinout[i] passed through SYNC_STAGES flops.
  - The pad is sampled in all states, so TX loops driven data back to dout.
  - An undriven, unterminated pad gives X, which is acceptable.
- Channels are fully independent; no shared state.

## Timing
- Reset (rst_n low at an edge): state=RX, cnt=0, oe=0, busy=0, drv_q=0, all sync flops 0, so dout=0.
  - Reset applies mid-turnaround or mid-drive; the pad is released after that edge.
- Drive request: z sampled 0 at edge n in RX → busy=1 after n. oe=1 and busy=0 after edge n+TURN_CYC.
  - With TURN_CYC=0: oe=1 after edge n, busy never asserts.
- Release: z sampled 1 at edge m in TX → oe=0 after edge m (one-cycle latency, never longer).
  - busy=1 from m to m+TURN_CYC; RX after edge m+TURN_CYC.
  - The earliest re-drive is TURN_CYC+1 edges later, giving 2·TURN_CYC dead cycles for a full round trip.
- Data: din sampled at edge k appears on the pad after edge k while in TX.
  - dout reflects a pad change SYNC_STAGES edges after it becomes stable.
- Simultaneous events: z toggling every cycle in RX/TURN_TX gives no drive. A single-cycle z=1 pulse in TX always forces the full TURN_RX.

## Configuration
- IOBUF_BANK_OPEN_DRAIN_EN defined: in TX the pad is driven 0 when drv_q=0 and released (1'bz) when drv_q=1. The board supplies the pull-up. The FSM, oe, busy and turnaround timing are unchanged.
- Undefined: push-pull drive, as described in Operation.

## Structure
- iobuf_bank_pkg:
  - typedef for the state enum: RX=2'd0, TURN_TX=2'd1, TX=2'd2, TURN_RX=2'd3.
  - Localparams for the TURN_CYC and SYNC_STAGES limits.
- Sub-module iobuf_chan: one channel (FSM, counter, drv_q, synchroniser, pad driver). iobuf_bank is a generate loop of CH iobuf_chan instances plus parameter range assertions.

## Test plan
Use CH=3, TURN_CYC=1, SYNC_STAGES=2, clk period 2 ns, each channel's pad weakly pulled to 1 from the bench.
1. Reset with z=3'b111, din=3'b010, then release rst_n → oe=0, busy=0, dout=0 for 2 edges, then dout=3'b111 from the pull-ups.
2. Drop z[0] to 0 with din[0]=0 → busy[0]=1 for 1 cycle, then oe[0]=1, pad 0, dout[0]=0 two edges later. Channels 1 and 2 are unaffected.
3. z[2] goes 1→0→1 within 2 edges (aborted request) → oe[2] never asserts, busy[2] pulses once, state back to RX.
4. In TX, toggle din[1] 1→0 → pad follows one edge later and dout[1] follows two edges after that. Then raise z[1] → oe[1]=0 after one edge, busy[1]=1 for 1 cycle, re-drive no earlier than 2 edges later.
5. Assert rst_n low while channel 0 is in TX with drv_q=0 → oe[0]=0 and pad released after that edge; dout=0 during reset.
6. With IOBUF_BANK_OPEN_DRAIN_EN, drive din[0]=1 in TX → pad=1'bz (reads 1 via the pull-up) while oe[0]=1; din[0]=0 → pad=0.
